bram_port_responder: RTL and testbench

//  Synthesizable responder for the single-port BRAM_PORTA_0 interface (addr/din/dout/en/we).

---
 rtl/bram_pkg.sv | 23 ++
 rtl/bram_rd_pipe.sv | 67 ++++++
 rtl/bram_port_responder.sv | 122 ++++++++++++
 tb/tb_bram_port_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_pkg
// Brief    : Shared write-mode codes, FSM encoding and width defaults for the
//            BRAM_PORTA_0 responder and its initiators.
// Revision : 1.0  initial release
// ============================================================================
package bram_pkg;

    localparam int BRAM_ADDR_W = 13;
    localparam int BRAM_DATA_W = 8;

    localparam int WM_WRITE_FIRST = 0;
    localparam int WM_READ_FIRST  = 1;
    localparam int WM_NO_CHANGE   = 2;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bram_rd_pipe
// Brief    : Read-data output pipeline (1 or 2 stages) with hold-on-idle dout
//            and a per-result valid pulse.
// Revision : 1.0  initial release
// ============================================================================
module bram_rd_pipe #(
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] w_stage_data;
    logic              w_stage_vld;
    logic [DATA_W-1:0] dout_q;
    logic              valid_q;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_W-1:0] s1_data_q;
            logic              s1_vld_q;

            // Stage 1 only loads on a real access so idle cycles never disturb dout.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    s1_data_q <= '0;
                    s1_vld_q  <= 1'b0;
                end else begin
                    s1_vld_q <= valid_i;
                    if (valid_i) begin
                        s1_data_q <= data_i;
                    end
                end
            end

            assign w_stage_data = s1_data_q;
            assign w_stage_vld  = s1_vld_q;
        end else begin : g_lat1
            assign w_stage_data = data_i;
            assign w_stage_vld  = valid_i;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= w_stage_vld;
            if (w_stage_vld) begin
                dout_q <= w_stage_data;
            end
        end
    end

    assign dout_o  = dout_q;
    assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/bram_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_responder
// Brief    : Single-port BRAM model: init sweep, configurable read latency and
//            write mode, sticky out-of-range flag.
// Revision : 1.0  initial release
// ============================================================================
module bram_port_responder
    import bram_pkg::*;
#(
    parameter int                 ADDR_W       = BRAM_ADDR_W,
    parameter int                 DATA_W       = BRAM_DATA_W,
    parameter int                 DEPTH        = 8192,
    parameter int                 READ_LATENCY = 1,
    parameter int                 WRITE_MODE   = WM_WRITE_FIRST,
    parameter logic [DATA_W-1:0]  INIT_VALUE   = '0
) (
    input  logic              BRAM_PORTA_0_clk,
    input  logic              BRAM_PORTA_0_rst,
    input  logic [ADDR_W-1:0] BRAM_PORTA_0_addr,
    input  logic [DATA_W-1:0] BRAM_PORTA_0_din,
    output logic [DATA_W-1:0] BRAM_PORTA_0_dout,
    input  logic              BRAM_PORTA_0_en,
    input  logic              BRAM_PORTA_0_we,
    output logic              init_busy,
    output logic              rd_valid,
    output logic              oob_err
);

    localparam int c_mem_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    state_t              state_q;
    logic [c_mem_aw-1:0] ptr_q;
    logic                init_busy_q;
    logic                oob_err_q;

    logic                w_ready;
    logic                w_oob;
    logic                w_user_wr;
    logic                w_wr_en;
    logic                w_rd_vld;
    logic [c_mem_aw-1:0] w_idx;
    logic [c_mem_aw-1:0] w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_rd_data;

    assign w_ready   = (state_q == ST_READY);
    assign w_oob     = ({1'b0, BRAM_PORTA_0_addr} >= (ADDR_W + 1)'(DEPTH));
    assign w_idx     = BRAM_PORTA_0_addr[c_mem_aw-1:0];
    assign w_user_wr = w_ready && BRAM_PORTA_0_en && BRAM_PORTA_0_we && !w_oob;
    assign w_wr_en   = !BRAM_PORTA_0_rst && ((state_q == ST_INIT) || w_user_wr);
    assign w_waddr   = w_ready ? w_idx : ptr_q;
    assign w_wdata   = w_ready ? BRAM_PORTA_0_din : INIT_VALUE;
    assign w_rd_vld  = w_ready && BRAM_PORTA_0_en &&
                       (!BRAM_PORTA_0_we || (WRITE_MODE != WM_NO_CHANGE));

    // Read data as seen at the capturing edge; the array write lands on the same edge.
    always_comb begin
        w_rd_data = mem_q[w_idx];
        if (w_oob) begin
            w_rd_data = '0;
        end else if (BRAM_PORTA_0_we) begin
            case (WRITE_MODE)
                WM_WRITE_FIRST: w_rd_data = BRAM_PORTA_0_din;
                WM_READ_FIRST:  w_rd_data = mem_q[w_idx];
                default:        w_rd_data = mem_q[w_idx];
            endcase
        end
    end

    always_ff @(posedge BRAM_PORTA_0_clk) begin
        if (w_wr_en) begin
            mem_q[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge BRAM_PORTA_0_clk) begin
        if (BRAM_PORTA_0_rst) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            init_busy_q <= 1'b1;
            oob_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == c_mem_aw'(DEPTH - 1)) begin
                        state_q     <= ST_READY;
                        init_busy_q <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (BRAM_PORTA_0_en && w_oob) begin
                        oob_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_INIT;
                    init_busy_q <= 1'b1;
                end
            endcase
        end
    end

    bram_rd_pipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk_i   (BRAM_PORTA_0_clk),
        .rst_i   (BRAM_PORTA_0_rst),
        .data_i  (w_rd_data),
        .valid_i (w_rd_vld),
        .dout_o  (BRAM_PORTA_0_dout),
        .valid_o (rd_valid)
    );

    assign init_busy = init_busy_q;
    assign oob_err   = oob_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_port_responder
// Brief    : Four responder configurations (WF/RF/NC at latency 1, WF at
//            latency 2) driven in parallel and checked against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_bram_port_responder;

    localparam int NCFG = 4;
    localparam int DEP  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [12:0] addr = '0;
    logic [7:0]  din = '0;
    logic        en = 1'b0;
    logic        we = 1'b0;

    logic [7:0]  dout_w [NCFG];
    logic        busy_w [NCFG];
    logic        vld_w  [NCFG];
    logic        oob_w  [NCFG];

    int n_checks = 0;
    int n_errors = 0;

    always #2 clk = ~clk;

    function automatic int wm_of(input int k);
        return (k == 1) ? 1 : (k == 2) ? 2 : 0;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    generate
        for (genvar g = 0; g < NCFG; g++) begin : g_dut
            bram_port_responder #(
                .ADDR_W       (13),
                .DATA_W       (8),
                .DEPTH        (DEP),
                .READ_LATENCY ((g == 3) ? 2 : 1),
                .WRITE_MODE   ((g == 1) ? 1 : (g == 2) ? 2 : 0),
                .INIT_VALUE   (8'h00)
            ) u_dut (
                .BRAM_PORTA_0_clk  (clk),
                .BRAM_PORTA_0_rst  (rst),
                .BRAM_PORTA_0_addr (addr),
                .BRAM_PORTA_0_din  (din),
                .BRAM_PORTA_0_dout (dout_w[g]),
                .BRAM_PORTA_0_en   (en),
                .BRAM_PORTA_0_we   (we),
                .init_busy         (busy_w[g]),
                .rd_valid          (vld_w[g]),
                .oob_err           (oob_w[g])
            );
        end
    endgenerate

    // Reference model: memory contents, results delayed by a queue of length = latency.
    logic [7:0] mmem [NCFG][DEP];
    logic [8:0] pq   [NCFG][$];
    logic [7:0] exp_dout [NCFG];
    logic       exp_vld  [NCFG];
    logic       exp_oob  [NCFG];
    logic       exp_busy;
    int         busy_left = 0;

    task automatic model_edge();
        logic ready;
        ready = (busy_left == 0);
        for (int k = 0; k < NCFG; k++) begin
            logic [8:0] r;
            logic       oa;
            if (rst) begin
                exp_dout[k] = 8'h00;
                exp_vld[k]  = 1'b0;
                exp_oob[k]  = 1'b0;
                pq[k].delete();
            end else begin
                r = '0;
                if (ready && en) begin
                    oa = (addr >= 13'(DEP));
                    if (!(we && wm_of(k) == 2))
                        r = {1'b1, oa ? 8'h00 : (we && wm_of(k) == 0) ? din : mmem[k][addr[3:0]]};
                    if (we && !oa) mmem[k][addr[3:0]] = din;
                    if (oa) exp_oob[k] = 1'b1;
                end
                pq[k].push_back(r);
                if (pq[k].size() == lat_of(k)) begin
                    r = pq[k].pop_front();
                    exp_vld[k] = r[8];
                    if (r[8]) exp_dout[k] = r[7:0];
                end
            end
        end
        if (rst) begin
            busy_left = DEP;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                for (int k = 0; k < NCFG; k++)
                    for (int a = 0; a < DEP; a++) mmem[k][a] = 8'h00;
            end
        end
        exp_busy = (busy_left != 0);
    endtask

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s[cfg%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < NCFG; k++) begin
            check("dout",      k, 32'(dout_w[k]), 32'(exp_dout[k]));
            check("rd_valid",  k, 32'(vld_w[k]),  32'(exp_vld[k]));
            check("oob_err",   k, 32'(oob_w[k]),  32'(exp_oob[k]));
            check("init_busy", k, 32'(busy_w[k]), 32'(exp_busy));
        end
    endtask

    task automatic acc(input logic e, input logic w, input logic [12:0] a, input logic [7:0] d);
        en = e; we = w; addr = a; din = d;
        tick();
    endtask

    task automatic reset_and_sweep(input int tag_id);
        int cnt;
        rst = 1'b1;
        en = 1'b0; we = 1'b0;
        tick();
        rst = 1'b0;
        cnt = 0;
        while (busy_w[0] === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        check("busy_cycles", tag_id, 32'(cnt), 32'(DEP));
    endtask

    initial begin
        // 1: reset, init sweep length, all-zero contents
        reset_and_sweep(0);
        for (int a = 0; a < DEP; a++) acc(1'b1, 1'b0, 13'(a), 8'h00);
        acc(1'b0, 1'b0, '0, '0);

        // 2: write then reads
        acc(1'b1, 1'b1, 13'd1, 8'h02);
        acc(1'b1, 1'b0, 13'd2, 8'h00);
        acc(1'b1, 1'b0, 13'd1, 8'h00);
        check("dir_rd1", 0, 32'(dout_w[0]), 32'h02);
        acc(1'b0, 1'b0, '0, '0);

        // 3: we without en does nothing; dout holds while idle
        acc(1'b0, 1'b1, 13'd3, 8'h55);
        acc(1'b0, 1'b1, 13'd3, 8'h55);
        acc(1'b1, 1'b0, 13'd3, 8'h00);
        acc(1'b0, 1'b0, 13'd3, 8'h00);
        acc(1'b0, 1'b0, 13'd7, 8'h00);
        check("dir_hold3", 0, 32'(dout_w[0]), 32'h00);

        // 4: write-mode behaviour on a rewrite
        acc(1'b1, 1'b1, 13'd4, 8'hAA);
        acc(1'b1, 1'b1, 13'd4, 8'h5B);
        check("dir_wf", 0, 32'(dout_w[0]), 32'h5B);
        check("dir_rf", 1, 32'(dout_w[1]), 32'hAA);
        check("dir_nc_vld", 2, 32'(vld_w[2]), 32'h0);
        acc(1'b1, 1'b0, 13'd4, 8'h00);
        acc(1'b0, 1'b0, '0, '0);

        // 5: back-to-back reads (latency-2 instance shows 3 consecutive results)
        acc(1'b1, 1'b0, 13'd1, 8'h00);
        acc(1'b1, 1'b0, 13'd2, 8'h00);
        acc(1'b1, 1'b0, 13'd1, 8'h00);
        acc(1'b0, 1'b0, '0, '0);
        acc(1'b0, 1'b0, '0, '0);

        // 6a: out-of-range read, sticky flag
        acc(1'b1, 1'b0, 13'd20, 8'h00);
        acc(1'b0, 1'b0, '0, '0);
        acc(1'b0, 1'b0, '0, '0);
        check("dir_oob", 0, 32'(oob_w[0]), 32'h1);

        // Random traffic, occasionally out of range
        for (int i = 0; i < 250; i++) begin
            int sel;
            logic [12:0] ra;
            sel = int'($urandom_range(0, 19));
            ra  = (sel == 0) ? 13'($urandom) : (sel == 1) ? 13'($urandom_range(16, 19))
                                             : 13'($urandom_range(0, DEP - 1));
            acc($urandom_range(0, 3) != 0, 1'($urandom), ra, 8'($urandom));
        end
        acc(1'b0, 1'b0, '0, '0);

        // 6b: reset while the sweep is at pointer 7 restarts it from 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) acc(1'b1, 1'b1, 13'($urandom_range(0, DEP - 1)), 8'($urandom));
        reset_and_sweep(1);
        check("dir_oob_clr", 0, 32'(oob_w[0]), 32'h0);
        for (int a = 0; a < DEP; a++) acc(1'b1, 1'b0, 13'(a), 8'h00);
        acc(1'b0, 1'b0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
